// File: rtl/ysyx_23060236_trap_csr_if.sv
// Commit-stage bundle between the ysyx_23060236 pipeline and its machine-mode CSR/trap unit.
// Carries CSR access, trap sources, interrupt levels and the redirect/MMU responses.
interface ysyx_23060236_trap_csr_if #(
    parameter int NUM_LIRQ = 4
);
    // valid marks the instruction in the stage as committing this cycle; there is no
    // back-pressure, so every response below is combinational within the same cycle.
    logic                valid;
    logic [11:0]         csr_addr;
    logic [1:0]          csr_op;
    logic [31:0]         csr_wdata;
    logic [31:0]         csr_rdata;
    logic                inst_ecall;
    logic                inst_ebreak;
    logic                inst_mret;
    logic                exc_valid;
    logic [4:0]          exc_cause;
    logic [31:0]         exc_tval;
    logic [31:0]         epc;
    logic                irq_timer;
    logic                irq_ext;
    logic [NUM_LIRQ-1:0] irq_local;
    logic [31:0]         trap_pc;
    logic                trap_en;
    logic                mmu_on;
    logic [19:0]         ppn;
    logic                tlb_flush;

    modport master (
        output valid, csr_addr, csr_op, csr_wdata,
        output inst_ecall, inst_ebreak, inst_mret,
        output exc_valid, exc_cause, exc_tval, epc,
        output irq_timer, irq_ext, irq_local,
        input  csr_rdata, trap_pc, trap_en, mmu_on, ppn, tlb_flush
    );

    modport slave (
        input  valid, csr_addr, csr_op, csr_wdata,
        input  inst_ecall, inst_ebreak, inst_mret,
        input  exc_valid, exc_cause, exc_tval, epc,
        input  irq_timer, irq_ext, irq_local,
        output csr_rdata, trap_pc, trap_en, mmu_on, ppn, tlb_flush
    );
endinterface

// File: rtl/ysyx_23060236_trap_csr.sv
// Machine-mode CSR file and trap unit: exceptions, mie/mip interrupts, optional vectored
// mtvec, 64-bit mcycle/minstret, and satp-derived MMU controls.
module ysyx_23060236_trap_csr #(
    parameter int          NUM_LIRQ  = 4,
    parameter bit          VECTORED  = 1'b1,
    parameter logic [31:0] MVENDORID = 32'h7973_7978,
    parameter logic [31:0] MARCHID   = 32'h015f_df0c
) (
    input logic                     clock,
    input logic                     reset,
    ysyx_23060236_trap_csr_if.slave bus
);

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_SATP      = 12'h180;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
    localparam logic [11:0] ADDR_MARCHID   = 12'hF12;

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [31:0] LIRQ_MASK   = 32'(((64'd1 << NUM_LIRQ) - 64'd1) << 16);
    localparam logic [31:0] MIE_MASK    = LIRQ_MASK | 32'h0000_0888;
    localparam logic [31:0] MSTATUS_MPP = 32'h0000_1800;

    logic        status_mie;
    logic        status_mpie;
    logic [31:0] mie_r;
    logic [31:0] mtvec_r;
    logic [31:0] mscratch_r;
    logic [31:0] mepc_r;
    logic        mcause_int;
    logic [4:0]  mcause_code;
    logic [31:0] mtval_r;
    logic        msip;
    logic [31:0] satp_r;
    logic [63:0] mcycle;
    logic [63:0] minstret;

    logic [31:0] mstatus_v;
    logic [31:0] mip_v;
    logic [31:0] mcause_v;
    logic [31:0] pending;

    // Architectural views; mip's hardware bits follow the input levels directly.
    always_comb begin
        mstatus_v     = MSTATUS_MPP;
        mstatus_v[7]  = status_mpie;
        mstatus_v[3]  = status_mie;
        mip_v         = '0;
        mip_v[3]      = msip;
        mip_v[7]      = bus.irq_timer;
        mip_v[11]     = bus.irq_ext;
        mip_v[16 +: NUM_LIRQ] = bus.irq_local;
        mcause_v      = {mcause_int, 26'd0, mcause_code};
        pending       = mip_v & mie_r;
    end

    // Written lowest priority first so the highest-priority pending source lands last.
    logic [4:0] int_code;
    always_comb begin
        int_code = 5'd0;
        for (int i = NUM_LIRQ - 1; i >= 0; i--) begin
            if (pending[16 + i]) int_code = 5'(16 + i);
        end
        if (pending[7])  int_code = 5'd7;
        if (pending[3])  int_code = 5'd3;
        if (pending[11]) int_code = 5'd11;
    end

    logic int_take;
    logic exc_take;
    logic sys_take;
    logic trap_take;
    logic csr_take;
    logic mret_take;

    assign int_take  = bus.valid & status_mie & (pending != 32'd0);
    assign exc_take  = bus.valid & ~int_take & bus.exc_valid;
    assign sys_take  = bus.valid & ~int_take & ~bus.exc_valid & (bus.inst_ecall | bus.inst_ebreak);
    assign trap_take = int_take | exc_take | sys_take;
    assign csr_take  = bus.valid & ~trap_take & (bus.csr_op != OP_NONE);
    assign mret_take = bus.valid & ~trap_take & ~csr_take & bus.inst_mret;

    logic [4:0] trap_code;
    always_comb begin
        if (int_take)             trap_code = int_code;
        else if (bus.exc_valid)   trap_code = bus.exc_cause;
        else if (bus.inst_ecall)  trap_code = 5'd11;
        else                      trap_code = 5'd3;
    end

    logic [31:0] rdata;
    logic        writable;
    always_comb begin
        rdata    = 32'd0;
        writable = 1'b1;
        case (bus.csr_addr)
            ADDR_MSTATUS:   rdata = mstatus_v;
            ADDR_MIE:       rdata = mie_r;
            ADDR_MTVEC:     rdata = mtvec_r;
            ADDR_MSCRATCH:  rdata = mscratch_r;
            ADDR_MEPC:      rdata = mepc_r;
            ADDR_MCAUSE:    rdata = mcause_v;
            ADDR_MTVAL:     rdata = mtval_r;
            ADDR_MIP:       rdata = mip_v;
            ADDR_SATP:      rdata = satp_r;
            ADDR_MCYCLE:    rdata = mcycle[31:0];
            ADDR_MCYCLEH:   rdata = mcycle[63:32];
            ADDR_MINSTRET:  rdata = minstret[31:0];
            ADDR_MINSTRETH: rdata = minstret[63:32];
            ADDR_MVENDORID: begin
                rdata    = MVENDORID;
                writable = 1'b0;
            end
            ADDR_MARCHID: begin
                rdata    = MARCHID;
                writable = 1'b0;
            end
            default:        writable = 1'b0;
        endcase
    end

    logic [31:0] csr_new;
    always_comb begin
        case (bus.csr_op)
            OP_WRITE: csr_new = bus.csr_wdata;
            OP_SET:   csr_new = rdata | bus.csr_wdata;
            OP_CLEAR: csr_new = rdata & ~bus.csr_wdata;
            default:  csr_new = rdata;
        endcase
    end

    // Set/clear with a zero operand is a pure read and must not disturb any state.
    logic do_write;
    assign do_write = csr_take & writable &
                      ((bus.csr_op == OP_WRITE) | (bus.csr_wdata != 32'd0));

    logic [31:0] tvec_base;
    logic [31:0] next_pc;
    assign tvec_base = {mtvec_r[31:2], 2'b00};

    always_comb begin
        if (int_take && VECTORED && (mtvec_r[1:0] == 2'b01))
            next_pc = tvec_base + {25'd0, int_code, 2'b00};
        else if (trap_take)
            next_pc = tvec_base;
        else if (bus.inst_mret)
            next_pc = mepc_r;
        else
            next_pc = tvec_base;
    end

    assign bus.csr_rdata = rdata;
    assign bus.trap_pc   = next_pc;
    assign bus.trap_en   = ~reset & bus.valid &
                           (int_take | bus.exc_valid | bus.inst_ecall |
                            bus.inst_ebreak | bus.inst_mret);
    assign bus.mmu_on    = satp_r[31];
    assign bus.ppn       = satp_r[19:0];
    assign bus.tlb_flush = do_write & (bus.csr_addr == ADDR_SATP);

    always_ff @(posedge clock) begin
        if (reset) begin
            status_mie  <= 1'b0;
            status_mpie <= 1'b0;
            mie_r       <= 32'd0;
            mtvec_r     <= 32'd0;
            mscratch_r  <= 32'd0;
            mepc_r      <= 32'd0;
            mcause_int  <= 1'b0;
            mcause_code <= 5'd0;
            mtval_r     <= 32'd0;
            msip        <= 1'b0;
            satp_r      <= 32'd0;
            mcycle      <= 64'd0;
            minstret    <= 64'd0;
        end else begin
            mcycle <= mcycle + 64'd1;
            if (bus.valid && !trap_take) minstret <= minstret + 64'd1;

            if (trap_take) begin
                mepc_r      <= {bus.epc[31:2], 2'b00};
                mcause_int  <= int_take;
                mcause_code <= trap_code;
                mtval_r     <= exc_take ? bus.exc_tval : 32'd0;
                status_mpie <= status_mie;
                status_mie  <= 1'b0;
            end else if (mret_take) begin
                status_mie  <= status_mpie;
                status_mpie <= 1'b1;
            end else if (do_write) begin
                // Counter writes below override the increments above for that cycle.
                case (bus.csr_addr)
                    ADDR_MSTATUS: begin
                        status_mie  <= csr_new[3];
                        status_mpie <= csr_new[7];
                    end
                    ADDR_MIE:       mie_r      <= csr_new & MIE_MASK;
                    ADDR_MTVEC:     mtvec_r    <= VECTORED ? csr_new : {csr_new[31:2], 2'b00};
                    ADDR_MSCRATCH:  mscratch_r <= csr_new;
                    ADDR_MEPC:      mepc_r     <= {csr_new[31:2], 2'b00};
                    ADDR_MCAUSE: begin
                        mcause_int  <= csr_new[31];
                        mcause_code <= csr_new[4:0];
                    end
                    ADDR_MTVAL:     mtval_r    <= csr_new;
                    ADDR_MIP:       msip       <= csr_new[3];
                    ADDR_SATP:      satp_r     <= csr_new;
                    ADDR_MCYCLE:    mcycle     <= {mcycle[63:32], csr_new};
                    ADDR_MCYCLEH:   mcycle     <= {csr_new, mcycle[31:0]};
                    ADDR_MINSTRET:  minstret   <= {minstret[63:32], csr_new};
                    ADDR_MINSTRETH: minstret   <= {csr_new, minstret[31:0]};
                    default: ;
                endcase
            end
        end
    end

endmodule
